mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle 32-bit MIPS datapath.
- Walks each instruction through its fetch/decode/execute/memory/writeback steps and drives every datapath enable and mux select.
- Produces the 2-bit ALUOp consumed by the ALU control block, so it sits on the producer side of that interface.
- Stalls on a simple memory-ready handshake.

Parameters:
- OPW, 6, opcode width (instr[31:26]).
- STW, 4, state register width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- opcode  in  OPW  instr[31:26] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct (to ALU control).
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_dbg  out  STW  current state.

Behaviour:
- Single registered state; all outputs are Moore-decoded from state, except the mem_ready-gated outputs noted below.
- Every output not listed for a state is 0.
- Reset:
  - rst_n low at a rising edge puts state in IDLE, including mid-instruction.
  - In IDLE all outputs are 0 and state_dbg = 0.
  - First cycle after reset release: IDLE -> FETCH unconditionally.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and transitions:
  - FETCH (1): mem_read=1, alu_src_b=01, alu_op=00; pc_write=ir_write=mem_ready. Stay while !mem_ready, else -> DECODE.
  - DECODE (2): alu_src_b=11, alu_op=00.
    - LW/SW -> MEM_ADDR; RTYPE -> EXEC; BEQ -> BRANCH; J -> JUMP.
    - ADDI -> EXEC_I (feature on only).
    - Any other opcode -> FETCH with illegal_op=1 this cycle.
  - MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD (4): mem_read=1, i_or_d=1. Stay while !mem_ready, else -> MEM_WB.
  - MEM_WB (5): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
  - MEM_WR (6): mem_write=1, i_or_d=1; instr_done=mem_ready. Stay while !mem_ready, else -> FETCH.
  - EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - R_WB (8): reg_write=1, reg_dst=1, instr_done=1 -> FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
  - JUMP (10): pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - Unreachable encodings -> IDLE next cycle, all outputs 0.
- Latency with mem_ready held high: RTYPE 4, LW 5, SW 4, BEQ 3, J 3 cycles; each cycle with mem_ready low adds one cycle in the waiting state.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- pc_write and mem_write are never asserted in the same cycle.

Optional Feature:
- Macro: MIPS_CTRL_ADDI_EN.
- Defined:
  - DECODE routes ADDI to EXEC_I (11): alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB.
  - I_WB (12): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
  - ADDI latency is 4 cycles.
- Undefined: ADDI is illegal (illegal_op pulse, return to FETCH); encodings 11 and 12 are unreachable.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants, 4 bits;
  - opcode constants;
  - ALUOp constants, also used by the ALU control block;
  - alu_src_b and pc_source constants.
- One natural sub-module, mips_ctrl_outdec: purely combinational, state + mem_ready -> control outputs.
- The FSM and next-state logic stay in the top module.

Test Plan:
- rst_n low 2 cycles then high, mem_ready=1 -> state_dbg 0, then 1; all outputs 0 during reset.
- RTYPE with mem_ready=1 -> states 1,2,7,8,1; alu_op=10 in EXEC; reg_write=reg_dst=1 in R_WB; instr_done in cycle 4.
- LW with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles.
- BEQ then J -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01; JUMP: pc_write=1, pc_source=10; 3 cycles each.
- Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH; ADDI behaves the same when the macro is undefined.
- rst_n low during MEM_WR with mem_ready=0 -> next state IDLE, mem_write drops to 0; with MIPS_CTRL_ADDI_EN defined, ADDI -> states 1,2,11,12.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU control block.
// Optional ADDI support is enabled with the MIPS_CTRL_ADDI_EN macro.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_EXEC_I   = 4'd11,
        ST_I_WB     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/memory status in, enables and selects out.
interface mips_multicycle_ctrl_if #(
    parameter int OPW = 6,
    parameter int STW = 4
) ();
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           instr_done;
    logic           illegal_op;
    logic [STW-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state_dbg
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: state plus mem_ready to datapath controls.
// EXEC_I / I_WB decode only exists when MIPS_CTRL_ADDI_EN is defined.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Moore decode; FETCH and MEM_WR additionally qualify on mem_ready
    always_comb begin
        ctrl = '0;
        case (state)
            ST_IDLE: begin
                ctrl = '0;
            end
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath; outputs decoded by mips_ctrl_outdec.
// Defining MIPS_CTRL_ADDI_EN adds the ADDI path (EXEC_I, I_WB).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_e state_r;
    state_e next_s;
    logic   illegal_s;
    ctrl_t  ctrl_s;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        next_s    = ST_IDLE;
        illegal_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    next_s = ST_DECODE;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_s = ST_MEM_ADDR;
                    OP_RTYPE:     next_s = ST_EXEC;
                    OP_BEQ:       next_s = ST_BRANCH;
                    OP_J:         next_s = ST_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      next_s = ST_EXEC_I;
`endif
                    default: begin
                        next_s    = ST_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                // An opcode that is neither LW nor SW here abandons the access
                if (bus.opcode == OP_SW) begin
                    next_s = ST_MEM_WR;
                end else if (bus.opcode == OP_LW) begin
                    next_s = ST_MEM_RD;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_MEM_RD: begin
                if (bus.mem_ready) begin
                    next_s = ST_MEM_WB;
                end else begin
                    next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_MEM_WR;
                end
            end
            ST_MEM_WB: next_s = ST_FETCH;
            ST_EXEC:   next_s = ST_R_WB;
            ST_R_WB:   next_s = ST_FETCH;
            ST_BRANCH: next_s = ST_FETCH;
            ST_JUMP:   next_s = ST_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            ST_EXEC_I: next_s = ST_I_WB;
            ST_I_WB:   next_s = ST_FETCH;
`endif
            default:   next_s = ST_IDLE;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_s)
    );

    assign bus.pc_write      = ctrl_s.pc_write;
    assign bus.pc_write_cond = ctrl_s.pc_write_cond;
    assign bus.i_or_d        = ctrl_s.i_or_d;
    assign bus.mem_read      = ctrl_s.mem_read;
    assign bus.mem_write     = ctrl_s.mem_write;
    assign bus.ir_write      = ctrl_s.ir_write;
    assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
    assign bus.reg_dst       = ctrl_s.reg_dst;
    assign bus.reg_write     = ctrl_s.reg_write;
    assign bus.alu_src_a     = ctrl_s.alu_src_a;
    assign bus.alu_src_b     = ctrl_s.alu_src_b;
    assign bus.alu_op        = ctrl_s.alu_op;
    assign bus.pc_source     = ctrl_s.pc_source;
    assign bus.instr_done    = ctrl_s.instr_done;
    assign bus.illegal_op    = illegal_s;
    assign bus.state_dbg     = STW'(state_r);

endmodule
